// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: 8-deep byte FIFO feeding an 11-bit frame serializer.
// Latency: start bit drives 2 cycles after a byte is accepted into an empty, idle unit.
// Backpressure: ready drops when FIFO is full; a write while full is dropped and sets sticky overflow.
// Optional PS2_TX_INHIBIT_EN: host clock-inhibit defers frame start and aborts/resends frames.
module ps2_kbd_tx #(
  parameter int CLK_DIV = 2000,
  parameter int GAP     = 4000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  input  logic       ps2_clk_in,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       overflow
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int GW = $clog2(GAP);
  localparam logic [CW-1:0] HI_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [8];
  logic [2:0]      wptr, rptr;
  logic [3:0]      count;
  logic [CW-1:0]   cyc;
  logic [3:0]      bit_idx;
  logic [GW-1:0]   gap_cnt;
  logic [9:0]      sh;
  logic            push, pop, load, abort, clk_ok, start_ok;
  logic [7:0]      head;

`ifdef PS2_TX_INHIBIT_EN
  logic [1:0] clk_sync;
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) clk_sync <= 2'b11;
    else       clk_sync <= {clk_sync[0], ps2_clk_in};
  end
  assign clk_ok = clk_sync[1];
`else
  logic unused_clk_in;
  assign unused_clk_in = ps2_clk_in;
  assign clk_ok = 1'b1;
`endif

  assign ready    = (count != 4'd8);
  assign busy     = (state != ST_IDLE);
  assign push     = valid & ready;
  assign head     = mem[rptr];
  assign start_ok = (count != 4'd0) && clk_ok;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 3'd1;
      if (pop)  rptr <= rptr + 3'd1;
      count <= count + {3'b0, push} - {3'b0, pop};
      if (valid && !ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // GAP exit goes straight to SEND so back-to-back frames see exactly GAP idle cycles.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = 1'b0;
    abort     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nxt = ST_SEND;
          load      = 1'b1;
        end
      end
      ST_SEND: begin
        if (cyc == HI_LAST && bit_idx != 4'd10 && !clk_ok) begin
          abort     = 1'b1;
          state_nxt = ST_GAP;
        end else if (cyc == CYC_LAST && bit_idx == 4'd10) begin
          pop       = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (start_ok) begin
            state_nxt = ST_SEND;
            load      = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cyc      <= '0;
      bit_idx  <= '0;
      gap_cnt  <= '0;
      sh       <= '0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else if (load) begin
      sh       <= {1'b1, ~^head, head};
      ps2_data <= 1'b0;
      ps2_clk  <= 1'b1;
      cyc      <= '0;
      bit_idx  <= '0;
    end else if (abort || pop) begin
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      gap_cnt  <= '0;
    end else if (state == ST_SEND) begin
      if (cyc == CYC_LAST) begin
        cyc      <= '0;
        bit_idx  <= bit_idx + 4'd1;
        ps2_clk  <= 1'b1;
        ps2_data <= sh[0];
        sh       <= {1'b0, sh[9:1]};
      end else begin
        cyc <= cyc + CW'(1);
        if (cyc == HI_LAST) ps2_clk <= 1'b0;
      end
    end else if (state == ST_GAP) begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end

endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2000: ps2_clk half-period in clk cycles (>=4).
REQ-002 SHALL have parameter GAP, default 4000: idle clk cycles between frames (>=2).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 clrn  input  1  reset; one clock, reset asynchronous active-low.
REQ-005 data  input  8  scan-code byte to send.
REQ-006 valid  input  1  write strobe; byte accepted when valid & ready.
REQ-007 ready  output  1  FIFO not full.
REQ-008 ps2_clk_in  input  1  sensed PS/2 clock line (host may pull low).
REQ-009 ps2_clk  output  1  driven PS/2 clock, idle high.
REQ-010 ps2_data  output  1  driven PS/2 data, idle high.
REQ-011 busy  output  1  high in SEND or GAP.
REQ-012 overflow  output  1  sticky: a write was attempted while full.

Function
REQ-013 SHALL hold an 8-entry byte FIFO, 3-bit wrapping pointers, 4-bit count; ready = (count != 8), from registered count.
REQ-014 Write when full SHALL be dropped and set overflow, even if a pop occurs the same cycle.
REQ-015 FSM states IDLE, SEND, GAP; IDLE->SEND when count != 0 (and not inhibited, REQ-026); head byte copied to shift register, not popped.
REQ-016 Frame SHALL be 11 bits: start 0, data[0..7] LSB first, odd parity (~^data), stop 1.
REQ-017 Each bit period = 2*CLK_DIV cycles: ps2_data set at period start, ps2_clk high for CLK_DIV cycles, then low for CLK_DIV cycles; ps2_data stable whole period.
REQ-018 After stop-bit low phase: ps2_clk high, ps2_data high, FIFO pop, SEND->GAP; GAP lasts GAP cycles, then IDLE.
REQ-019 Latency: byte accepted at cycle T with FIFO empty and FSM idle -> start bit on ps2_data at T+2; first ps2_clk fall at T+2+CLK_DIV.
REQ-020 Simultaneous push and pop (not full) SHALL leave count unchanged and both take effect.
REQ-021 Back-to-back frames SHALL be separated by exactly GAP cycles of both lines high.
REQ-022 Outputs ps2_clk/ps2_data SHALL be registered (glitch-free).

Reset
REQ-023 On clrn low, immediately: FSM IDLE, FIFO empty, pointers 0, ready 1, busy 0, overflow 0, ps2_clk 1, ps2_data 1.
REQ-024 Reset mid-frame SHALL abort the frame with no further edges; the byte is lost.
REQ-025 overflow SHALL clear only by reset.

Configuration
REQ-026 Macro PS2_TX_INHIBIT_EN defined: ps2_clk_in passes a 2-flop synchronizer; IDLE SHALL not start while synced value is 0; in SEND, synced value sampled on final cycle of each HIGH phase of bits 0..9; if 0, frame aborts: lines high, no pop, enter GAP, byte resent afterwards. Inhibit from bit 10 on is ignored.
REQ-027 Macro undefined: ps2_clk_in ignored, no synchronizer, frames never deferred or aborted.

Verification (CLK_DIV=4, GAP=8)
REQ-028 Push 0x1C at T -> ps2_data 0,0,0,1,1,1,0,0,0,0,1 (8 cycles each) from T+2; 11 ps2_clk falls; busy high 96 cycles.
REQ-029 Push 0x00 -> parity bit 1; push 0xFF -> parity bit 1; push 0x01 -> parity bit 0.
REQ-030 Nine consecutive pushes from empty -> first eight accepted, ready 0 after eighth, ninth dropped, overflow 1; eight frames emitted in order, 8-cycle gaps.
REQ-031 clrn low during bit 5 -> same-cycle ps2_clk=1, ps2_data=1, ready=1, busy=0; no edges after.
REQ-032 (PS2_TX_INHIBIT_EN) ps2_clk_in held 0 with byte queued -> no start; release -> start within 4 cycles; pull 0 across bit 3 HIGH phase -> abort, GAP, same byte resent complete.
